// File: rtl/matrix_stream_loader_if.sv
// rtl/matrix_stream_loader_if.sv - element stream in, 2x2 matrix out, framing error count
interface matrix_stream_loader_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic [DW-1:0] s_data;
  logic          s_first;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_out_1;
  logic [DW-1:0] m_out_2;
  logic [DW-1:0] m_out_3;
  logic [DW-1:0] m_out_4;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] err_cnt;

  modport slave (
    input  s_data, s_first, s_valid, m_ready,
    output s_ready, m_out_1, m_out_2, m_out_3, m_out_4, m_valid, err_cnt
  );

  modport master (
    output s_data, s_first, s_valid, m_ready,
    input  s_ready, m_out_1, m_out_2, m_out_3, m_out_4, m_valid, err_cnt
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - assembles byte-serial row-major 2x2 matrices for the transpose stage
module matrix_stream_loader #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input logic                   clk,
  input logic                   rst,
  matrix_stream_loader_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] fill_0, fill_1, fill_2;
  logic [DW-1:0] out_1, out_2, out_3, out_4;
  logic          out_valid;
  logic [CW-1:0] err_q;

  logic stall;
  logic accept;
  logic err_event;

  // Only the completing element waits on a full output register.
  assign stall       = (state == FILL3) && out_valid && !bus.m_ready;
  assign bus.s_ready = !rst && !stall;
  assign accept      = bus.s_valid && bus.s_ready;
  // Orphan from IDLE, or a new first marker abandoning a partial matrix.
  assign err_event   = accept && (bus.s_first ? (state != IDLE) : (state == IDLE));

  assign bus.m_out_1 = out_1;
  assign bus.m_out_2 = out_2;
  assign bus.m_out_3 = out_3;
  assign bus.m_out_4 = out_4;
  assign bus.m_valid = out_valid;
  assign bus.err_cnt = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_0    <= '0;
      fill_1    <= '0;
      fill_2    <= '0;
      out_1     <= '0;
      out_2     <= '0;
      out_3     <= '0;
      out_4     <= '0;
      out_valid <= 1'b0;
      err_q     <= '0;
    end else begin
      if (out_valid && bus.m_ready) begin
        out_valid <= 1'b0;
      end
      if (err_event && (err_q != {CW{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end
      if (accept) begin
        if (bus.s_first) begin
          fill_0 <= bus.s_data;
          state  <= FILL1;
        end else begin
          case (state)
            IDLE: state <= IDLE;
            FILL1: begin
              fill_1 <= bus.s_data;
              state  <= FILL2;
            end
            FILL2: begin
              fill_2 <= bus.s_data;
              state  <= FILL3;
            end
            FILL3: begin
              // Completion wins over a same-cycle drain, keeping m_valid high.
              out_1     <= fill_0;
              out_2     <= fill_1;
              out_3     <= fill_2;
              out_4     <= bus.s_data;
              out_valid <= 1'b1;
              state     <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb/tb_matrix_stream_loader.sv - scoreboard bench for matrix_stream_loader
module tb_matrix_stream_loader;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  bit   stress  = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  matrix_stream_loader_if #(.DW(8), .CW(8)) bus ();
  matrix_stream_loader_if #(.DW(8), .CW(2)) bus2 ();

  matrix_stream_loader #(.DW(8), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  matrix_stream_loader #(.DW(8), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [31:0] mat_now();
    return {bus.m_out_1, bus.m_out_2, bus.m_out_3, bus.m_out_4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected matrix.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_matrix actual=%h required=none", mat_now());
      end else begin
        mon_exp = exp_q.pop_front();
        if (mat_now() !== mon_exp) begin
          errors++;
          $display("FAIL matrix_out actual=%h required=%h", mat_now(), mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (stress) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] d, input bit f, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_first = f;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = bus.s_ready;
      step();
      waited++;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept data=%h", d);
    end
  endtask

  initial begin
    int w;
    logic [31:0] m;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_first = 1'b0; bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_first = 1'b0; bus2.m_ready = 1'b1;
    repeat (2) step();
    chk("reset_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("reset_m_out", mat_now(), 32'h0);
    chk("reset_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // Saturation on the CW=2 instance.
    bus2.s_valid = 1'b1; bus2.s_data = 8'h99;
    repeat (2) step();
    chk("sat_err_after_2", {30'd0, bus2.err_cnt}, 32'd2);
    repeat (3) step();
    bus2.s_valid = 1'b0;
    chk("sat_err_after_5", {30'd0, bus2.err_cnt}, 32'd3);

    // Single matrix
    exp_q.push_back(32'h11223344);
    send(8'h11, 1, w); send(8'h22, 0, w); send(8'h33, 0, w);
    chk("single_valid_before", {31'd0, bus.m_valid}, 32'd0);
    send(8'h44, 0, w);
    bus.s_valid = 1'b0;
    chk("single_valid_latency", {31'd0, bus.m_valid}, 32'd1);
    chk("single_out", mat_now(), 32'h11223344);
    chk("single_err", {24'd0, bus.err_cnt}, 32'd0);
    step();
    chk("single_drained", {31'd0, bus.m_valid}, 32'd0);

    // Back-to-back stall
    bus.m_ready = 1'b0;
    exp_q.push_back(32'h01020304);
    send(8'h01, 1, w); send(8'h02, 0, w); send(8'h03, 0, w); send(8'h04, 0, w);
    chk("stall_first_held", {31'd0, bus.m_valid}, 32'd1);
    exp_q.push_back(32'h05060708);
    send(8'h05, 1, w); chk("stall_accept_05", w, 1);
    send(8'h06, 0, w); chk("stall_accept_06", w, 1);
    send(8'h07, 0, w); chk("stall_accept_07", w, 1);
    bus.s_valid = 1'b1; bus.s_data = 8'h08; bus.s_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_s_ready_low", {31'd0, bus.s_ready}, 32'd0);
      chk("stall_out_held", mat_now(), 32'h01020304);
      step();
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_s_ready", {31'd0, bus.s_ready}, 32'd1);
    step();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    chk("stall_reload_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("stall_reload_out", mat_now(), 32'h05060708);
    bus.m_ready = 1'b1;
    step();
    chk("stall_final_drain", {31'd0, bus.m_valid}, 32'd0);

    // Premature restart
    exp_q.push_back(32'hB0B1B2B3);
    send(8'hA0, 1, w); send(8'hA1, 0, w);
    send(8'hB0, 1, w); send(8'hB1, 0, w); send(8'hB2, 0, w); send(8'hB3, 0, w);
    bus.s_valid = 1'b0;
    step();
    chk("restart_err", {24'd0, bus.err_cnt}, 32'd1);

    // Orphans from IDLE after a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    send(8'hC1, 0, w); send(8'hC2, 0, w); send(8'hC3, 0, w);
    bus.s_valid = 1'b0;
    step();
    chk("orphan_err", {24'd0, bus.err_cnt}, 32'd3);
    chk("orphan_no_valid", {31'd0, bus.m_valid}, 32'd0);

    // Mid-matrix reset with a held matrix
    bus.m_ready = 1'b0;
    send(8'h61, 1, w); send(8'h62, 0, w); send(8'h63, 0, w); send(8'h64, 0, w);
    send(8'h71, 1, w); send(8'h72, 0, w);
    bus.s_valid = 1'b0;
    chk("midrst_held_before", {31'd0, bus.m_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    step();
    chk("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("midrst_m_out", mat_now(), 32'h0);
    chk("midrst_err", {24'd0, bus.err_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_s_ready_after", {31'd0, bus.s_ready}, 32'd1);
    bus.m_ready = 1'b1;
    exp_q.push_back(32'h55565758);
    send(8'h55, 1, w); send(8'h56, 0, w); send(8'h57, 0, w); send(8'h58, 0, w);
    bus.s_valid = 1'b0;
    chk("midrst_fresh_out", mat_now(), 32'h55565758);
    step();

    // Random stress
    stress = 1'b1;
    for (int k = 0; k < 30; k++) begin
      m = $urandom;
      exp_q.push_back(m);
      for (int i = 0; i < 4; i++) begin
        send(m[31-8*i -: 8], i == 0, w);
        if ($urandom_range(0, 3) == 0) begin
          bus.s_valid = 1'b0;
          repeat ($urandom_range(1, 2)) step();
        end
      end
    end
    bus.s_valid = 1'b0;
    stress = 1'b0;
    bus.m_ready = 1'b1;
    repeat (5) step();
    chk("stress_queue_empty", exp_q.size(), 32'd0);
    chk("stress_err", {24'd0, bus.err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Upstream feeder for the 2x2 byte matrix transpose stage. It takes a byte-serial element stream through a valid/ready handshake and assembles each 2x2 matrix in row-major order. It also checks framing with a start-of-matrix marker. Each complete matrix is held in an output register whose four bytes drive the transpose inputs directly, under a valid/ready handshake.

## Interface
- `DW`, default 8: element width in bits; must match the transpose stage element width.
- `CW`, default 8: width of the framing-error counter.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_data`, in, DW: element byte.
- `s_first`, in, 1: marks element 0 (row 0, column 0) of a matrix.
- `s_valid`, in, 1: `s_data`/`s_first` valid.
- `s_ready`, out, 1: loader can accept an element this cycle.
- `m_out_1`, out, DW: matrix element [0][0]; drives transpose `in_1`.
- `m_out_2`, out, DW: matrix element [0][1]; drives transpose `in_2`.
- `m_out_3`, out, DW: matrix element [1][0]; drives transpose `in_3`.
- `m_out_4`, out, DW: matrix element [1][1]; drives transpose `in_4`.
- `m_valid`, out, 1: `m_out_1`..`m_out_4` hold a complete matrix.
- `m_ready`, in, 1: consumer takes the matrix this cycle.
- `err_cnt`, out, CW: saturating count of framing errors.

## Operation
- **Accept rule.** An element is accepted in a cycle where `s_valid && s_ready`.
- **Fill state.** `fill_cnt` counts 0..3 elements held in the fill buffer, with 3 fill bytes of DW bits each.
- **Fill state machine.**
  - IDLE (`fill_cnt`=0), accepted element with `s_first`=1: store as element 0, go to `fill_cnt`=1.
  - IDLE, accepted element with `s_first`=0 (orphan): discard the byte, increment `err_cnt`, stay IDLE.
  - `fill_cnt`=1 or 2, accepted element with `s_first`=0: store at index `fill_cnt`, then increment `fill_cnt`.
  - `fill_cnt`=1..3, accepted element with `s_first`=1 (premature restart): abandon the partial matrix, increment `err_cnt`, store the new byte as element 0, `fill_cnt`=1.
  - `fill_cnt`=3, accepted element with `s_first`=0: matrix complete. Copy the fill bytes and the new byte into the output register as `m_out_1`..`m_out_4`, set `m_valid`=1, `fill_cnt`=0.
- **Output register.** It keeps its contents while `m_valid && !m_ready`. A cycle with `m_valid && m_ready` and no completion clears `m_valid`; `m_out_*` keep their stale values.
- **Backpressure.** `s_ready = !rst && !(fill_cnt==3 && m_valid && !m_ready)`.
  - `s_ready` is combinational from `m_ready`; this path is intentional.
  - The stall applies only to the completing element. Elements 0..2 of the next matrix are accepted while the output register is full.
- **Simultaneous completion and drain.** Completion in the same cycle as `m_valid && m_ready`: the output register is reloaded with the new matrix and `m_valid` stays 1.
- **Restart at fill_cnt=3 under stall.** An element with `s_first`=1 while `fill_cnt`=3 and the output is stalled is not accepted, because `s_ready`=0. It must be held by the source.
- **err_cnt.** Saturates at 2^CW-1. Orphan and premature-restart events in the same cycle cannot occur; at most 1 increment per cycle.
- **Reset.** Reset applied mid-operation discards the partial fill and the held matrix; nothing is flushed. Reset values:
  - `m_valid`=0
  - `m_out_1`..`m_out_4`=0
  - `err_cnt`=0
  - `fill_cnt`=0
  - `s_ready`=0 while `rst`=1; `s_ready`=1 in the first cycle after `rst` deasserts.

## Timing
- **Latency.** The 4th element is accepted at edge N; `m_valid`=1 and the matrix is visible after edge N, i.e. from cycle N+1.
- **Throughput.** Sustained throughput is 1 element per cycle and 1 matrix per 4 cycles when the consumer keeps up. There are no bubbles with `m_ready` held at 1.
- **Consumer hold.** The consumer may hold `m_ready`=0 indefinitely. The loader then buffers up to 3 further elements and stalls on the 4th.
- **Output stability.** `m_out_*` and `m_valid` are registered and glitch-free. Downstream combinational transpose output is valid in the same cycle as `m_valid`.

## Test plan
- **Single matrix.** Reset, then send 0x11(first), 0x22, 0x33, 0x44 on consecutive cycles with `m_ready`=1. Required: `m_out_1..4`=0x11,0x22,0x33,0x44 and `m_valid`=1 exactly one cycle after 0x44 is accepted; `err_cnt`=0.
- **Back-to-back stall.** Send two matrices back-to-back (0x01..0x04, then 0x05..0x08) with `m_ready`=0. Required:
  - first matrix held;
  - 0x05..0x07 accepted;
  - `s_ready`=0 while 0x08 is presented.
  - Then raise `m_ready` for 1 cycle: 0x08 accepted that cycle, `m_valid` stays 1, and `m_out`=0x05..0x08 next cycle.
- **Premature restart.** Send 0xA0(first), 0xA1, 0xB0(first), 0xB1, 0xB2, 0xB3. Required: `err_cnt`=1, and the only matrix output is 0xB0..0xB3.
- **Orphans and saturation.** Send 3 orphan bytes (`s_first`=0) from IDLE. Required: `err_cnt`=3 and no `m_valid`. With CW=2, send 5 orphans: `err_cnt` stops at 3.
- **Mid-matrix reset.** Assert `rst` for 1 cycle after 2 elements of a matrix, while a previous matrix is held. Required: `m_valid`=0, `m_out`=0, `err_cnt`=0, and `s_ready`=0 during reset. A fresh 0x55..0x58 sequence then completes normally.
- **Random stress.** Random `s_valid`/`m_ready` with a scoreboard. Required: every complete well-framed matrix emerges once, in order, with no loss or duplication.
